logic_unit_arbiter: RTL and testbench
=====================================

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter SETTLE_CYC, default 2, number of clock cycles the shared logic unit's operands are held stable before its result is sampled; legal range 1..15.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, on ports clk and rst_n.
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-006 req0_ready / req1_ready  output  1  operation accepted this cycle when high together with the matching valid.
REQ-007 req0_op / req1_op  input  2  operation code: 00 zero, 01 AND, 10 OR, 11 XOR.
REQ-008 req0_a, req0_b / req1_a, req1_b  input  32 each  operands.
REQ-009 lu_f1, lu_f0  output  1 each  select lines to the shared logic unit, equal to op[1] and op[0] respectively.
REQ-010 lu_a, lu_b  output  32 each  operands to the shared logic unit.
REQ-011 lu_out  input  32  shared logic unit result.
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts the result.
REQ-014 resp_data  output  32  captured result.
REQ-015 resp_id  output  1  index of the requester that owns resp_data.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, WAIT and RESP, with exactly one operation in flight.
REQ-018 In IDLE, the block SHALL grant one requester: the only valid one, or, if both are valid, the one not granted last; after reset, req0 has priority.
REQ-019 The req*_ready output SHALL be high only in IDLE and only for the granted requester; it is combinational from the valids and the priority pointer.
REQ-020 On the accept handshake, the block SHALL register op, a and b into lu_f1, lu_f0, lu_a and lu_b, load the wait counter with SETTLE_CYC, update the priority pointer, record resp_id, and move to WAIT.
REQ-021 lu_* outputs SHALL be held unchanged through WAIT and RESP until the next accept.
REQ-022 In WAIT, the counter SHALL decrement each cycle; in the cycle it reads 1, the block SHALL capture lu_out into resp_data and move to RESP.
REQ-023 In RESP, resp_valid SHALL be 1; resp_data and resp_id SHALL be stable until the resp_valid && resp_ready handshake, after which the block returns to IDLE.
REQ-024 Latency: for an accept at edge T, resp_valid SHALL rise after edge T+SETTLE_CYC.
REQ-025 The next accept SHALL occur no earlier than the cycle after the response handshake.
REQ-026 If resp_ready is already high when RESP is entered, the handshake SHALL complete in that first RESP cycle.
REQ-027 A requester that drops valid before being granted SHALL forfeit its request, with no state change.
REQ-028 Op 00 SHALL be a legal operation whose result is whatever lu_out returns, nominally 0x00000000.
REQ-029 Requester inputs that change during WAIT or RESP SHALL have no effect.

Reset
REQ-030 On rst_n low, the block SHALL immediately enter IDLE and clear all registered outputs and state: lu_f1=0, lu_f0=0, lu_a=0, lu_b=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, counter=0, priority pointer favouring req0.
REQ-031 While rst_n is low, req0_ready and req1_ready SHALL be 0.
REQ-032 A reset asserted during WAIT or RESP SHALL discard the in-flight operation without producing a response.

Structure
REQ-033 The shared package SHALL hold the op-code constants (OP_ZERO, OP_AND, OP_OR, OP_XOR) and the state enumeration.
REQ-034 The design SHALL contain one sub-module, rr_arb2, a two-way round-robin grant with a pointer register and an update-on-accept input.

Verification
REQ-035 Single op, SETTLE_CYC=2: req0 op=01, a=0xF0F0F0F0, b=0xFF00FF00 -> accept, resp_valid two cycles later, resp_data=0xF000F000, resp_id=0.
REQ-036 Both requesters valid continuously: req0 XOR 0xAAAAAAAA^0x55555555 and req1 OR 0x0000000F|0x000000F0 -> grants alternate 0,1,0,1; results 0xFFFFFFFF and 0x000000FF with matching resp_id.
REQ-037 Response backpressure: resp_ready held low for 5 cycles in RESP -> resp_data, resp_id and lu_* stable; no req*_ready asserted; single handshake when resp_ready rises.
REQ-038 Reset during WAIT: rst_n pulsed low mid-wait -> all outputs at their reset values asynchronously; no response afterwards; the next request is accepted normally.
REQ-039 Op 00 with a=b=0xFFFFFFFF -> resp_data=0x00000000; and lu_f1/lu_f0 equal 0/0 throughout.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types and constants for the two-requester logic-unit arbiter.
package logic_unit_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [OP_W-1:0] OP_ZERO = 2'b00;
  localparam logic [OP_W-1:0] OP_AND  = 2'b01;
  localparam logic [OP_W-1:0] OP_OR   = 2'b10;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } lu_req_t;

endpackage

// File: rtl/logic_unit_arbiter_rr_arb2.sv
// Two-way round-robin grant; the pointer moves past the winner on accept.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       en,
  input  logic       accept,
  output logic [1:0] grant
);

  // ptr_q high means requester 1 has priority on a tie.
  logic ptr_q;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one combinational logic unit between two requesters, one op in flight.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              lu_f1,
  output logic              lu_f0,
  output logic [DATA_W-1:0] lu_a,
  output logic [DATA_W-1:0] lu_b,
  input  logic [DATA_W-1:0] lu_out,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_id,
  output logic              busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       grant;
  logic             arb_en;
  logic             accept;
  lu_req_t          req0_pl;
  lu_req_t          req1_pl;
  lu_req_t          sel_pl;

  // Ready is masked during reset so nothing looks accepted while rst_n is low.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .en     (arb_en),
    .accept (accept),
    .grant  (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  assign req0_pl = '{op: req0_op, a: req0_a, b: req0_b};
  assign req1_pl = '{op: req1_op, a: req1_a, b: req1_b};
  assign sel_pl  = grant[1] ? req1_pl : req0_pl;

  // Operation FSM; lu_* only change on accept so the unit sees stable operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lu_f1      <= 1'b0;
      lu_f0      <= 1'b0;
      lu_a       <= '0;
      lu_b       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lu_f1   <= sel_pl.op[1];
            lu_f0   <= sel_pl.op[0];
            lu_a    <= sel_pl.a;
            lu_b    <= sel_pl.b;
            cnt_q   <= CNT_W'(SETTLE_CYC);
            resp_id <= grant[1];
            busy    <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            resp_data  <= lu_out;
            resp_valid <= 1'b1;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter with a behavioural logic unit.
module tb_logic_unit_arbiter;
  import logic_unit_arbiter_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        lu_f1, lu_f0;
  logic [31:0] lu_a, lu_b, lu_out;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic_unit_arbiter #(.SETTLE_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .lu_f1      (lu_f1),
    .lu_f0      (lu_f0),
    .lu_a       (lu_a),
    .lu_b       (lu_b),
    .lu_out     (lu_out),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  // Behavioural shared logic unit.
  always_comb begin
    case ({lu_f1, lu_f0})
      OP_AND:  lu_out = lu_a & lu_b;
      OP_OR:   lu_out = lu_a | lu_b;
      OP_XOR:  lu_out = lu_a ^ lu_b;
      default: lu_out = 32'h0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req0_ready"}, 32'(req0_ready), 32'h0);
    check({tag, "_req1_ready"}, 32'(req1_ready), 32'h0);
    check({tag, "_lu_f1"},      32'(lu_f1),      32'h0);
    check({tag, "_lu_f0"},      32'(lu_f0),      32'h0);
    check({tag, "_lu_a"},       lu_a,            32'h0);
    check({tag, "_lu_b"},       lu_b,            32'h0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
    check({tag, "_resp_data"},  resp_data,       32'h0);
    check({tag, "_resp_id"},    32'(resp_id),    32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
  endtask

  task automatic wait_resp(input string tag, input int max_cyc);
    int n = 0;
    while (resp_valid !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_resp_seen"}, 32'(resp_valid), 32'h1);
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_op    = 2'b00; req0_a = '0; req0_b = '0;
    req1_op    = 2'b00; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;

    // Reset state, with both valids high to confirm readies stay low.
    tick();
    tick();
    check_reset_outputs("por");
    rst_n      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Single AND op from req0, latency SETTLE_CYC=2.
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'h1);
    check("t1_req1_ready", 32'(req1_ready), 32'h0);
    tick();
    req0_valid = 1'b0;
    check("t1_busy",   32'(busy),  32'h1);
    check("t1_lu_f1",  32'(lu_f1), 32'h0);
    check("t1_lu_f0",  32'(lu_f0), 32'h1);
    check("t1_lu_a",   lu_a,       32'hF0F0F0F0);
    check("t1_lu_b",   lu_b,       32'hFF00FF00);
    check("t1_rv_t0",  32'(resp_valid), 32'h0);
    tick();
    check("t1_rv_t1",  32'(resp_valid), 32'h0);
    tick();
    check("t1_rv_t2",  32'(resp_valid), 32'h1);
    check("t1_data",   resp_data,       32'hF000F000);
    check("t1_id",     32'(resp_id),    32'h0);
    resp_ready = 1'b1;
    tick();
    check("t1_rv_done",   32'(resp_valid), 32'h0);
    check("t1_busy_done", 32'(busy),       32'h0);
    resp_ready = 1'b0;

    // Backpressure on a req1 OR; requester inputs change mid-flight.
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h12340000; req1_b = 32'h00005678;
    #1;
    check("t2_req1_ready", 32'(req1_ready), 32'h1);
    tick();
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'hDEADBEEF; req0_b = 32'h1;
    req1_a = 32'hCAFEF00D; req1_op = 2'b01;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t2_rv",    32'(resp_valid), 32'h1);
      check("t2_data",  resp_data,       32'h12345678);
      check("t2_id",    32'(resp_id),    32'h1);
      check("t2_lu_a",  lu_a,            32'h12340000);
      check("t2_lu_op", 32'({lu_f1, lu_f0}), 32'h2);
      check("t2_rdy0",  32'(req0_ready), 32'h0);
      check("t2_rdy1",  32'(req1_ready), 32'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t2_rv_done", 32'(resp_valid), 32'h0);
    check("t2_busy",    32'(busy),       32'h0);
    resp_ready = 1'b0;
    tick();
    check("t2_single_hs", 32'(resp_valid), 32'h0);
    check("t2_idle",      32'(busy),       32'h0);

    // Op 00 with all-ones operands; resp_ready already high entering RESP.
    resp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'hFFFFFFFF; req0_b = 32'hFFFFFFFF;
    #1;
    check("t3_req0_ready", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    check("t3_f_wait0", 32'({lu_f1, lu_f0}), 32'h0);
    check("t3_lu_a",    lu_a,                32'hFFFFFFFF);
    tick();
    check("t3_f_wait1", 32'({lu_f1, lu_f0}), 32'h0);
    tick();
    check("t3_rv",     32'(resp_valid),     32'h1);
    check("t3_data",   resp_data,           32'h0);
    check("t3_f_resp", 32'({lu_f1, lu_f0}), 32'h0);
    tick();
    check("t3_hs_first", 32'(resp_valid), 32'h0);
    check("t3_busy",     32'(busy),       32'h0);
    resp_ready = 1'b0;

    // Reset in the middle of WAIT discards the op.
    req1_valid = 1'b1; req1_op = 2'b11; req1_a = 32'h1; req1_b = 32'h3;
    tick();
    check("t4_busy", 32'(busy), 32'h1);
    tick();
    req0_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_async");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_no_resp", 32'(resp_valid), 32'h0);
      check("t4_no_busy", 32'(busy),       32'h0);
    end

    // Both valid continuously: grants alternate starting with req0.
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 32'hAAAAAAAA; req0_b = 32'h55555555;
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 32'h0000000F; req1_b = 32'h000000F0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("t5_rdy1", 32'(req1_ready), (k % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      wait_resp("t5", 8);
      check("t5_data", resp_data, (k % 2 == 0) ? 32'hFFFFFFFF : 32'h000000FF);
      check("t5_id",   32'(resp_id), 32'(k % 2));
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
